telem_packet_packer: RTL and testbench

TELEM_PACKET_PACKER -- requirements
Module: telem_packet_packer

---
 rtl/telem_packet_packer.sv | 206 ++++++++++++++++++++
 tb/tb_telem_packet_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/telem_packet_packer.sv
// Telemetry packet packer: packet FIFO feeding a framer that emits SYNC header + data words.
// Define TELEM_PACKER_CRC_EN to append a CRC-16-CCITT word after the data words.
module telem_packet_packer #(
    parameter int          PACKET_WIDTH = 88,
    parameter int          DATA_WIDTH   = 16,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] SYNC_WORD    = 32'h0000_A5A5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PACKET_WIDTH-1:0]  packet,
    input  logic                     packet_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [15:0]              drop_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int NWORDS = (PACKET_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PADW   = NWORDS * DATA_WIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int FW     = AW + 1;
    localparam int CW     = $clog2(NWORDS + 1);
    localparam logic [DATA_WIDTH-1:0] SYNC = DATA_WIDTH'(SYNC_WORD);
`ifdef TELEM_PACKER_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
`ifdef TELEM_PACKER_CRC_EN
        , S_CRC
`endif
    } state_t;

    logic [PACKET_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [FW-1:0]           r_fill;
    logic                    r_in_ready;
    logic [15:0]             r_drop_count;
    logic                    r_overflow;

    state_t                  r_state;
    logic [PADW-1:0]         r_shift;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic                    r_out_last;

    logic                    w_full, w_empty, w_push, w_drop, w_pop, w_accept, w_last_data;
    logic [FW-1:0]           w_fill_nxt;
    logic [PADW-1:0]         w_padded;
    logic [DATA_WIDTH-1:0]   w_top;

    assign w_full     = (r_fill == FW'(DEPTH));
    assign w_empty    = (r_fill == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign w_push     = packet_valid & ~w_full;
    assign w_drop     = packet_valid & w_full;
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_fill_nxt = r_fill + FW'(w_push) - FW'(w_pop);

    assign w_padded    = PADW'(r_mem[r_rptr]) << (PADW - PACKET_WIDTH);
    assign w_top       = r_shift[PADW-1 -: DATA_WIDTH];
    assign w_accept    = r_out_valid & out_ready;
    assign w_last_data = (r_cnt == CW'(NWORDS - 1));

`ifdef TELEM_PACKER_CRC_EN
    logic [15:0]           r_crc;
    logic [15:0]           w_crc_nxt;
    logic [DATA_WIDTH-1:0] w_crc_word;

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [DATA_WIDTH-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // The CRC covers the data word currently presented, folded in as it is accepted.
    assign w_crc_nxt  = crc_step(r_crc, r_out_data);
    assign w_crc_word = DATA_WIDTH'(w_crc_nxt);
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= packet;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_fill       <= '0;
            r_in_ready   <= 1'b0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_fill     <= w_fill_nxt;
            r_in_ready <= (w_fill_nxt != FW'(DEPTH));
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef TELEM_PACKER_CRC_EN
            r_crc       <= 16'hFFFF;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_HDR;
                        r_shift     <= w_padded;
                        r_out_data  <= SYNC;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                    end
                end
                S_HDR: begin
`ifdef TELEM_PACKER_CRC_EN
                    r_crc <= 16'hFFFF;
`endif
                    if (w_accept) begin
                        r_state    <= S_DATA;
                        r_out_data <= w_top;
                        r_shift    <= r_shift << DATA_WIDTH;
                        r_cnt      <= '0;
                        r_out_last <= (NWORDS == 1) && !CRC_EN;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef TELEM_PACKER_CRC_EN
                        r_crc <= w_crc_nxt;
`endif
                        if (w_last_data) begin
`ifdef TELEM_PACKER_CRC_EN
                            r_state     <= S_CRC;
                            r_out_data  <= w_crc_word;
                            r_out_last  <= 1'b1;
`else
                            r_state     <= S_IDLE;
                            r_out_data  <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
`endif
                        end else begin
                            r_out_data <= w_top;
                            r_shift    <= r_shift << DATA_WIDTH;
                            r_cnt      <= r_cnt + 1'b1;
                            r_out_last <= !CRC_EN && (r_cnt == CW'(NWORDS - 2));
                        end
                    end
                end
`ifdef TELEM_PACKER_CRC_EN
                S_CRC: begin
                    if (w_accept) begin
                        r_state     <= S_IDLE;
                        r_out_data  <= '0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;
    assign fill_level = r_fill;

endmodule

// File: tb/tb_telem_packet_packer.sv
// Directed bench for telem_packet_packer at default parameters; frame length and the
// trailing CRC word follow TELEM_PACKER_CRC_EN.
module tb_telem_packet_packer;

    localparam int DW = 16;
    localparam int PW = 88;
    localparam int NW = 6;
`ifdef TELEM_PACKER_CRC_EN
    localparam int NF = NW + 2;
`else
    localparam int NF = NW + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] packet = '0;
    logic          packet_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [15:0]   drop_count;
    logic          overflow;
    logic [2:0]    fill_level;

    int n_chk  = 0;
    int n_fail = 0;

    telem_packet_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .packet       (packet),
        .packet_valid (packet_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .fill_level   (fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PW-1:0] p);
        packet       = p;
        packet_valid = 1'b1;
        tick();
        packet_valid = 1'b0;
    endtask

`ifdef TELEM_PACKER_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [NW*DW-1:0] bits);
        logic [15:0] c = 16'hFFFF;
        for (int i = NW*DW - 1; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
`endif

    // Waits at most max_wait cycles for the header, then checks every word of the frame,
    // optionally stalling out_ready for stall_n cycles on word stall_idx, and the idle gap after.
    task automatic expect_frame(input logic [PW-1:0] pkt, input int max_wait,
                                input int stall_idx, input int stall_n, input string tag);
        logic [NW*DW-1:0] pad;
        logic [DW-1:0]    w [NF];
        int               waited;
        pad  = {pkt, 8'h00};
        w[0] = 16'hA5A5;
        for (int i = 0; i < NW; i++) w[1+i] = pad[NW*DW-1-DW*i -: DW];
`ifdef TELEM_PACKER_CRC_EN
        w[NF-1] = crc_ref(pad);
`endif
        waited = 0;
        while (out_valid !== 1'b1 && waited < max_wait) begin
            tick();
            waited++;
        end
        chk({tag, "_hdr_vld"}, 32'(out_valid), 32'd1);
        if (out_valid !== 1'b1) return;
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("%s_w%0d_vld", tag, i), 32'(out_valid), 32'd1);
            chk($sformatf("%s_w%0d_data", tag, i), 32'(out_data), 32'(w[i]));
            chk($sformatf("%s_w%0d_last", tag, i), 32'(out_last), (i == NF-1) ? 32'd1 : 32'd0);
            if (i == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk($sformatf("%s_hold%0d_data", tag, s), 32'(out_data), 32'(w[i]));
                    chk($sformatf("%s_hold%0d_vld", tag, s), 32'(out_valid), 32'd1);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk({tag, "_idle_gap"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single frame with header latency N+2
        push(88'h112233445566778899AABB);
        chk("lat_fill_after_push", 32'(fill_level), 32'd1);
        chk("lat_no_early_valid", 32'(out_valid), 32'd0);
        expect_frame(88'h112233445566778899AABB, 1, -1, 0, "single");

        // Backpressure: stall 5 cycles on 3344
        push(88'h112233445566778899AABB);
        expect_frame(88'h112233445566778899AABB, 1, 2, 5, "bp");

        // Back-to-back frames with a single idle cycle between
        push(88'hDEADBEEF0123456789ABCD);
        push(88'hCAFEF00D_55AA55AA_0F0F0F);
        expect_frame(88'hDEADBEEF0123456789ABCD, 0, -1, 0, "b2b_a");
        expect_frame(88'hCAFEF00D_55AA55AA_0F0F0F, 1, -1, 0, "b2b_b");

        // Overflow while a stalled frame holds the framer
        out_ready = 1'b0;
        push(88'h0);
        tick();
        chk("ovf_blocker_hdr", 32'(out_valid), 32'd1);
        for (int k = 1; k <= 6; k++) push(PW'(k) * 88'h0101_0101_0101_0101_0101_01);
        chk("ovf_fill", 32'(fill_level), 32'd4);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_hdr_held", 32'(out_data), 32'hA5A5);
        out_ready = 1'b1;
        expect_frame(88'h0, 0, -1, 0, "zero");

        // Push while full coinciding with a pop: dropped, fill 4 -> 3
        chk("pp_fill_before", 32'(fill_level), 32'd4);
        packet       = 88'hFFEEDDCCBBAA9988776655;
        packet_valid = 1'b1;
        tick();
        packet_valid = 1'b0;
        chk("pp_fill_after", 32'(fill_level), 32'd3);
        chk("pp_drop", 32'(drop_count), 32'd3);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        for (int k = 1; k <= 4; k++)
            expect_frame(PW'(k) * 88'h0101_0101_0101_0101_0101_01, (k == 1) ? 0 : 1, -1, 0,
                         $sformatf("ovf_q%0d", k));
        chk("ovf_drained", 32'(fill_level), 32'd0);

        // Reset in the middle of a frame, with another packet queued
        push(88'h112233445566778899AABB);
        push(88'h0123456789ABCDEF012345);
        tick();
        tick();
        tick();
        chk("mid_word3", 32'(out_data), 32'h5566);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_fill", 32'(fill_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_post_fill", 32'(fill_level), 32'd0);
        chk("mid_post_drop", 32'(drop_count), 32'd0);
        chk("mid_post_ovf", 32'(overflow), 32'd0);
        chk("mid_post_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mid_no_stale_frame", 32'(out_valid), 32'd0);
        push(88'h0F1E2D3C4B5A6978877665);
        expect_frame(88'h0F1E2D3C4B5A6978877665, 1, -1, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
